// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the iterative integer divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned TIMER_W   = 6;

  // Two's-complement magnitude; 0x80000000 maps to itself and is read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_ctrl_if;

  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_cancel;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output div_start, div_signed, dividend, divisor, div_cancel,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  div_start, div_signed, dividend, divisor, div_cancel,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/div_iter_step.sv
// One combinational restoring-division step on a 64-bit shifting minuend.
module div_iter_step (
  input  logic [63:0] minuend,
  input  logic [31:0] dvs,
  input  logic [31:0] q_iter,
  output logic [63:0] minuend_next,
  output logic [31:0] q_next
);

  logic [32:0] diff;

  // Bit 32 of the difference acts as the borrow: set means the trial subtract failed.
  assign diff         = minuend[63:31] - {1'b0, dvs};
  assign q_next       = {q_iter[30:0], ~diff[32]};
  assign minuend_next = diff[32] ? {minuend[62:0], 1'b0}
                                 : {diff[31:0], minuend[30:0], 1'b0};

endmodule

// File: rtl/div_ctrl.sv
// Sequential divider controller: operand capture, 32 restoring steps, sign fix-up.
module div_ctrl
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  div_ctrl_if.slave  bus
);

  localparam logic [TIMER_W-1:0] LastStep = TIMER_W'(DIV_STEPS - 1);

  div_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [63:0]        minuend_q, minuend_step;
  logic [31:0]        q_iter_q, q_iter_step;
  logic [31:0]        dvs_q;
  logic               neg_a_q, neg_b_q;
  logic [31:0]        quotient_q, remainder_q;
  logic               accept;

  // A new request is only taken when no operation is running and no flush is pending.
  assign accept = bus.div_start && !bus.div_cancel &&
                  (state_q == DIV_IDLE || state_q == DIV_DONE);

  div_iter_step u_step (
    .minuend      (minuend_q),
    .dvs          (dvs_q),
    .q_iter       (q_iter_q),
    .minuend_next (minuend_step),
    .q_next       (q_iter_step)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DIV_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; cancel overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (accept) state_d = DIV_ITER;
      DIV_ITER: if (timer_q == LastStep) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: state_d = accept ? DIV_ITER : DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (bus.div_cancel) state_d = DIV_IDLE;
  end

  // Datapath: operand capture, iteration and sign fix-up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q     <= '0;
      minuend_q   <= '0;
      q_iter_q    <= '0;
      dvs_q       <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (accept) begin
      neg_a_q   <= bus.div_signed & bus.dividend[31];
      neg_b_q   <= bus.div_signed & bus.divisor[31];
      minuend_q <= {32'b0, abs32(bus.dividend, bus.div_signed & bus.dividend[31])};
      dvs_q     <= abs32(bus.divisor, bus.div_signed & bus.divisor[31]);
      q_iter_q  <= '0;
      timer_q   <= '0;
    end else if (!bus.div_cancel) begin
      if (state_q == DIV_ITER) begin
        minuend_q <= minuend_step;
        q_iter_q  <= q_iter_step;
        timer_q   <= timer_q + 1'b1;
      end else if (state_q == DIV_FIX) begin
        quotient_q  <= abs32(q_iter_q, neg_a_q ^ neg_b_q);
        remainder_q <= abs32(minuend_q[63:32], neg_a_q);
      end
    end
  end

  assign bus.busy      = (state_q == DIV_ITER) || (state_q == DIV_FIX);
  assign bus.done      = (state_q == DIV_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op in the current cycle (cycle 0); expects busy in 1..33 and done in 34.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input bit glitch);
    int bad_window = 0;
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_start  = 1'b1;
    tick();
    bus.div_start  = 1'b0;
    bus.dividend   = 32'hDEADBEEF;
    bus.divisor    = 32'h0000_0001;
    bus.div_signed = ~s;
    for (int c = 1; c < 34; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_window++;
      bus.div_start = (glitch && c == 5);
      tick();
    end
    chk({tag, "_window"}, 32'(bad_window), 32'd0);
    chk({tag, "_done"},   32'(bus.done), 32'd1);
    chk({tag, "_busy"},   32'(bus.busy), 32'd0);
    chk({tag, "_q"},      bus.quotient, exp_q);
    chk({tag, "_r"},      bus.remainder, exp_r);
  endtask

  initial begin
    int cnt;
    resetn         = 1'b0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.div_cancel = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q",    bus.quotient,  32'd0);
    chk("rst_r",    bus.remainder, 32'd0);
    resetn = 1'b1;
    tick();

    // Basic op with a start pulse while busy, then back-to-back ops from the done cycle.
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    run_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    tick();
    run_op("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_op("divu_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("divu_5_0",   1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    tick();
    chk("done_pulse", 32'(bus.done), 32'd0);

    // Cancel in cycle 10 of a 100/7 op.
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    bus.div_start  = 1'b1;
    tick();
    bus.div_start  = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    bus.div_cancel = 1'b1;
    tick();
    bus.div_cancel = 1'b0;
    chk("cancel_busy", 32'(bus.busy), 32'd0);
    chk("cancel_done", 32'(bus.done), 32'd0);
    chk("cancel_q",    bus.quotient,  32'hFFFF_FFFF);
    chk("cancel_r",    bus.remainder, 32'd5);
    run_op("after_cancel", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    tick();

    // Start and cancel in the same cycle: request dropped.
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd9;
    bus.divisor    = 32'd4;
    bus.div_start  = 1'b1;
    bus.div_cancel = 1'b1;
    tick();
    bus.div_start  = 1'b0;
    bus.div_cancel = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) cnt++;
      tick();
    end
    chk("start_cancel_dropped", 32'(cnt), 32'd0);
    chk("start_cancel_q", bus.quotient,  32'd14);
    chk("start_cancel_r", bus.remainder, 32'd2);

    // Asynchronous reset in the middle of iteration.
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd1000;
    bus.divisor    = 32'd3;
    bus.div_start  = 1'b1;
    tick();
    bus.div_start  = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_q",    bus.quotient,  32'd0);
    chk("arst_r",    bus.remainder, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    run_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequential control and datapath wrapper for the execute-stage integer divider (MIPS DIV/DIVU).
- Accepts operands from the EX stage and converts signed operands to magnitudes.
- Iterates a combinational restoring-division step 32 times, applies sign fix-up, and returns quotient/remainder for the HI/LO write.

Parameters:
- none (datapath fixed at 32 bits; iteration count fixed at 32)

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- div_start  in  1  request; sampled only when busy=0
- div_signed  in  1  1 = DIV (signed), 0 = DIVU
- dividend  in  32  operand A, sampled with div_start
- divisor  in  32  operand B, sampled with div_start
- div_cancel  in  1  pipeline flush; kills the operation in flight
- busy  out  1  operation in progress; start ignored
- done  out  1  one-cycle pulse; results valid
- quotient  out  32  LO value, held until next done
- remainder  out  32  HI value, held until next done

Behaviour:
- Reset (resetn=0, async): state=IDLE, busy=0, done=0, quotient=0, remainder=0, timer=0, internal minuend/quotient registers=0.
- States:
  - IDLE: waiting for a request.
  - ITER: one division step per cycle.
  - FIX: sign fix-up.
  - DONE: results presented.
- busy = (state==ITER || state==FIX).
- IDLE/DONE + div_start=1 (no cancel): capture operands.
  - neg_a = div_signed & dividend[31]; neg_b = div_signed & divisor[31].
  - minuend = {32'b0, |dividend|}, dvs = |divisor|, q_iter=0, timer=0 → ITER.
  - Magnitude is the two's-complement negate when the neg flag is set; 0x80000000 negates to itself and is treated as unsigned.
- ITER, per edge:
  - diff = minuend[63:31] − {1'b0,dvs} (33 bits).
  - q_iter ← (q_iter<<1) + !diff[32].
  - minuend ← (diff[32] ? minuend : {diff,minuend[30:0]}) << 1.
  - timer++.
  - After the edge where timer becomes 32 → FIX (exactly 32 steps).
- FIX, one edge:
  - quotient ← (neg_a^neg_b) ? −q_iter : q_iter.
  - remainder ← neg_a ? −minuend[63:32] : minuend[63:32].
  - → DONE.
- DONE: done=1 for exactly one cycle; next state IDLE, or ITER if div_start is accepted that same cycle.
- Latency: div_start high in cycle 0 → busy high cycles 1..33 → done high cycle 34. Back-to-back throughput is one op per 34 cycles.
- div_cancel=1 (synchronous, highest priority):
  - Next state IDLE, no done pulse.
  - quotient/remainder keep their previous values.
  - A div_start in the same cycle is dropped.
- div_start while busy: ignored, no queuing.
- Divide by zero (no trap, natural algorithm result):
  - DIVU gives q=0xFFFFFFFF, r=dividend.
  - DIV applies the sign rules above to that result.
- Overflow 0x80000000 / 0xFFFFFFFF signed: q=0x80000000, r=0.
- Operand inputs may change after the capture cycle without effect.

Decomposition:
- Shared package (div_pkg):
  - state encoding: DIV_IDLE, DIV_ITER, DIV_FIX, DIV_DONE
  - DIV_STEPS=32 and timer width 6
  - helper function abs32
- Natural sub-module: div_iter_step, the combinational single restoring step (minuend, divisor, q_iter in; next minuend, next q_iter out), instantiated once inside div_ctrl.
- div_ctrl owns the FSM, timer, operand/sign registers and fix-up.

Test Plan:
- DIVU 100/7, start cycle 0 → done cycle 34 only; q=14, r=2; busy high cycles 1..33.
- DIV −7/2 (0xFFFFFFF9, 0x00000002) → q=0xFFFFFFFD, r=0xFFFFFFFF. Also 7/−2 → q=0xFFFFFFFD, r=1.
- DIV 0x80000000/0xFFFFFFFF → q=0x80000000, r=0. DIVU same operands → q=0, r=0x80000000.
- DIVU 5/0 → q=0xFFFFFFFF, r=5; no hang, done at cycle 34.
- div_cancel in cycle 10 of a 100/7 op → busy=0 in cycle 11, no done, outputs unchanged. New start in cycle 11 completes correctly at cycle 45. Also: start+cancel in the same cycle → dropped.
- Back-to-back: second start asserted in the done cycle is accepted and completes 34 cycles later. Start pulses while busy are ignored. resetn dropped mid-ITER → all outputs 0 immediately.
